// File: rtl/lcd_bus_if.sv
// HD44780-style 8-bit LCD write bus as driven by the display controller.
// The master modport is the controller side, the slave modport the responder.
interface lcd_bus_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en);
    modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_en);
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible write-bus responder with a 2x16 character buffer and busy timing.
// Optional LCD_BUSY_CHECK_EN: en activity while busy is flagged as an error instead of queued.
module lcd_bus_responder #(
    parameter int EN_MIN_HIGH = 12,
    parameter int BUSY_SHORT  = 2000,
    parameter int BUSY_LONG   = 82000
) (
    input  logic       clk,
    input  logic       reset,
    lcd_bus_if.slave   bus,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic       protocol_err
);
    localparam int HW = $clog2(EN_MIN_HIGH + 1);
    localparam int BW = $clog2(BUSY_LONG + 1);
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_EN_HIGH = 3'd2,
        S_EXEC    = 3'd3,
        S_CLEAR   = 3'd4,
        S_BUSY    = 3'd5
    } state_t;

    state_t          state_r;
    logic            en_sync1_r, en_sync2_r, en_prev_r;
    logic            rs_d1_r, rs_d2_r, rw_d1_r, rw_d2_r;
    logic [7:0]      data_d1_r, data_d2_r;
    logic [HW-1:0]   hi_cnt_r;
    logic [BW-1:0]   busy_cnt_r;
    logic [4:0]      sweep_r;
    logic [6:0]      ac_r;
    logic            id_r, display_on_r, cgram_r, err_r, busy_r;
    logic            cmd_strobe_r, data_strobe_r;
    logic            op_rs_r;
    logic [7:0]      op_data_r;
    logic            pend_valid_r, pend_rs_r;
    logic [7:0]      pend_data_r;
`ifndef LCD_BUSY_CHECK_EN
    logic            bg_pulse_r;
`endif
    logic [7:0]      buf_r [0:31];
    logic [7:0]      rd_char_r;
    logic            rise_s, fall_s, short_s;
    logic            wr_en_s;
    logic [4:0]      wr_idx_s;
    logic [7:0]      wr_val_s;

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == 7'h27)      nxt = 7'h40;
            else if (ac == 7'h67) nxt = 7'h00;
            else                  nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      nxt = 7'h67;
            else if (ac == 7'h40) nxt = 7'h27;
            else                  nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Synchronize en; delay rs/rw/data by the same two stages so they stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sync1_r <= 1'b0;
            en_sync2_r <= 1'b0;
            en_prev_r  <= 1'b0;
            rs_d1_r    <= 1'b0;
            rs_d2_r    <= 1'b0;
            rw_d1_r    <= 1'b0;
            rw_d2_r    <= 1'b0;
            data_d1_r  <= 8'h00;
            data_d2_r  <= 8'h00;
        end else begin
            en_sync1_r <= bus.lcd_en;
            en_sync2_r <= en_sync1_r;
            en_prev_r  <= en_sync2_r;
            rs_d1_r    <= bus.lcd_rs;
            rs_d2_r    <= rs_d1_r;
            rw_d1_r    <= bus.lcd_rw;
            rw_d2_r    <= rw_d1_r;
            data_d1_r  <= bus.lcd_data;
            data_d2_r  <= data_d1_r;
        end
    end

    assign rise_s  = en_sync2_r & ~en_prev_r;
    assign fall_s  = ~en_sync2_r & en_prev_r;
    assign short_s = (hi_cnt_r < HW'(EN_MIN_HIGH));

    // Width of the current en high phase, saturating once it is long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_r <= '0;
        end else if (rise_s) begin
            hi_cnt_r <= HW'(1);
        end else if (en_sync2_r && short_s) begin
            hi_cnt_r <= hi_cnt_r + HW'(1);
        end else begin
            hi_cnt_r <= hi_cnt_r;
        end
    end

    // Main control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_INIT;
            busy_r        <= 1'b1;
            sweep_r       <= 5'd0;
            busy_cnt_r    <= '0;
            ac_r          <= 7'h00;
            id_r          <= 1'b1;
            display_on_r  <= 1'b0;
            cgram_r       <= 1'b0;
            err_r         <= 1'b0;
            cmd_strobe_r  <= 1'b0;
            data_strobe_r <= 1'b0;
            op_rs_r       <= 1'b0;
            op_data_r     <= 8'h00;
            pend_valid_r  <= 1'b0;
            pend_rs_r     <= 1'b0;
            pend_data_r   <= 8'h00;
`ifndef LCD_BUSY_CHECK_EN
            bg_pulse_r    <= 1'b0;
`endif
        end else begin
            cmd_strobe_r  <= 1'b0;
            data_strobe_r <= 1'b0;
            case (state_r)
                S_INIT, S_CLEAR: begin
                    sweep_r <= sweep_r + 5'd1;
                    if (sweep_r == 5'd31) begin
                        if (state_r == S_INIT) begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r    <= S_BUSY;
                            busy_cnt_r <= BW'(BUSY_LONG - 2);
                        end
                    end
                end
                S_IDLE: begin
                    if (pend_valid_r) begin
                        op_rs_r      <= pend_rs_r;
                        op_data_r    <= pend_data_r;
                        pend_valid_r <= 1'b0;
                        state_r      <= S_EXEC;
                        busy_r       <= 1'b1;
                    end else if (rise_s) begin
                        state_r <= S_EN_HIGH;
                    end
                end
                S_EN_HIGH: begin
                    if (fall_s) begin
                        if (short_s || rw_d2_r) begin
                            err_r   <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            op_rs_r   <= rs_d2_r;
                            op_data_r <= data_d2_r;
                            state_r   <= S_EXEC;
                            busy_r    <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state_r    <= S_BUSY;
                    busy_cnt_r <= BW'(BUSY_SHORT - 2);
                    if (op_rs_r) begin
                        data_strobe_r <= 1'b1;
                        if (!cgram_r) ac_r <= ac_step(ac_r, id_r);
                    end else begin
                        cmd_strobe_r <= 1'b1;
                        if (op_data_r[7]) begin
                            cgram_r <= 1'b0;
                            if (ddram_valid(op_data_r[6:0])) ac_r <= op_data_r[6:0];
                            else                             err_r <= 1'b1;
                        end else if (op_data_r[6]) begin
                            cgram_r <= 1'b1;
                        end else if (op_data_r[5]) begin
                            if (!op_data_r[4]) err_r <= 1'b1;
                        end else if (op_data_r[4]) begin
                            if (!op_data_r[3]) ac_r <= ac_step(ac_r, op_data_r[2]);
                        end else if (op_data_r[3]) begin
                            display_on_r <= op_data_r[2];
                        end else if (op_data_r[2]) begin
                            id_r <= op_data_r[1];
                        end else if (op_data_r[1]) begin
                            ac_r       <= 7'h00;
                            busy_cnt_r <= BW'(BUSY_LONG - 2);
                        end else if (op_data_r[0]) begin
                            ac_r    <= 7'h00;
                            id_r    <= 1'b1;
                            sweep_r <= 5'd0;
                            state_r <= S_CLEAR;
                        end
                    end
                end
                S_BUSY: begin
                    if (busy_cnt_r == '0) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_cnt_r <= busy_cnt_r - BW'(1);
                    end
                end
                default: begin
                    state_r <= S_INIT;
                    busy_r  <= 1'b1;
                    sweep_r <= 5'd0;
                end
            endcase
`ifdef LCD_BUSY_CHECK_EN
            if (rise_s && busy_r) err_r <= 1'b1;
`else
            // A pulse that starts while busy is parked; a newer one replaces it
            if (rise_s && busy_r) bg_pulse_r <= 1'b1;
            else if (fall_s)      bg_pulse_r <= 1'b0;
            if (fall_s && bg_pulse_r) begin
                if (short_s || rw_d2_r) begin
                    err_r <= 1'b1;
                end else begin
                    pend_valid_r <= 1'b1;
                    pend_rs_r    <= rs_d2_r;
                    pend_data_r  <= data_d2_r;
                end
            end
`endif
        end
    end

    // Buffer write source: blanking sweep or an on-screen data write
    always_comb begin
        wr_en_s  = 1'b0;
        wr_idx_s = 5'd0;
        wr_val_s = BLANK;
        if (reset) begin
            wr_en_s = 1'b0;
        end else if ((state_r == S_INIT) || (state_r == S_CLEAR)) begin
            wr_en_s  = 1'b1;
            wr_idx_s = sweep_r;
        end else if ((state_r == S_EXEC) && op_rs_r && !cgram_r && (ac_r[5:4] == 2'b00)) begin
            wr_en_s  = 1'b1;
            wr_idx_s = {ac_r[6], ac_r[3:0]};
            wr_val_s = op_data_r;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Character buffer storage
    always_ff @(posedge clk) begin
        if (wr_en_s) buf_r[wr_idx_s] <= wr_val_s;
    end

    // Registered read port; a same-cycle write is seen on the following read
    always_ff @(posedge clk) begin
        if (reset) rd_char_r <= 8'h00;
        else       rd_char_r <= buf_r[rd_addr];
    end

    assign rd_char      = rd_char_r;
    assign busy         = busy_r;
    assign cursor_addr  = ac_r;
    assign display_on   = display_on_r;
    assign cmd_strobe   = cmd_strobe_r;
    assign data_strobe  = data_strobe_r;
    assign protocol_err = err_r;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized self-checking bench for lcd_bus_responder against a behavioural display model.
// Timing parameters are scaled down so the long busy windows stay short in simulation.
module tb_lcd_bus_responder;
    localparam int EN_MIN  = 12;
    localparam int B_SHORT = 150;
    localparam int B_LONG  = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy;
    logic [6:0] cursor_addr;
    logic       display_on, cmd_strobe, data_strobe, protocol_err;

    lcd_bus_if bus();

    lcd_bus_responder #(.EN_MIN_HIGH(EN_MIN), .BUSY_SHORT(B_SHORT), .BUSY_LONG(B_LONG)) dut (
        .clk(clk), .reset(reset), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
        .busy(busy), .cursor_addr(cursor_addr), .display_on(display_on),
        .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cmd_seen = 0;
    int dat_seen = 0;

    // Count strobe-high cycles so stretched pulses show up as extra counts
    always @(negedge clk) begin
        if (cmd_strobe)  cmd_seen <= cmd_seen + 1;
        if (data_strobe) dat_seen <= dat_seen + 1;
    end

    // Display model
    logic [7:0] buf_m [0:31];
    logic [6:0] ac_m;
    logic       id_m, disp_m, cg_m, err_m;
    int         cmd_m = 0;
    int         dat_m = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic up);
        int v;
        v = up ? int'(a) + 1 : int'(a) - 1;
        if (v == 40)       v = 64;
        else if (v == 104) v = 0;
        else if (v == -1)  v = 103;
        else if (v == 63)  v = 39;
        return 7'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) buf_m[i] = 8'h20;
        ac_m = 7'h00; id_m = 1'b1; disp_m = 1'b0; cg_m = 1'b0; err_m = 1'b0;
    endtask

    task automatic model_apply(input logic rs, input logic [7:0] d, output int blen);
        int a;
        blen = B_SHORT;
        a = int'(ac_m);
        if (rs) begin
            dat_m++;
            if (!cg_m) begin
                if (a < 16)                 buf_m[a] = d;
                else if (a >= 64 && a < 80) buf_m[a - 48] = d;
                ac_m = ac_next(ac_m, id_m);
            end
        end else begin
            cmd_m++;
            if (d >= 8'd128) begin
                cg_m = 1'b0;
                if (d[6:0] <= 7'd39 || (d[6:0] >= 7'd64 && d[6:0] <= 7'd103)) ac_m = d[6:0];
                else err_m = 1'b1;
            end else if (d >= 8'd64) cg_m = 1'b1;
            else if (d >= 8'd32) begin
                if (!d[4]) err_m = 1'b1;
            end else if (d >= 8'd16) begin
                if (!d[3]) ac_m = ac_next(ac_m, d[2]);
            end else if (d >= 8'd8) disp_m = d[2];
            else if (d >= 8'd4) id_m = d[1];
            else if (d >= 8'd2) begin
                ac_m = 7'h00; blen = B_LONG;
            end else if (d == 8'd1) begin
                for (int i = 0; i < 32; i++) buf_m[i] = 8'h20;
                ac_m = 7'h00; id_m = 1'b1; blen = 32 + B_LONG;
            end
        end
    endtask

    task automatic lcd_pulse(input logic rs, input logic rw, input logic [7:0] d, input int width);
        @(posedge clk); #1;
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d;
        repeat (2) @(posedge clk);
        #1 bus.lcd_en = 1'b1;
        repeat (width) @(posedge clk);
        #1 bus.lcd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.lcd_rw = 1'b0;
    endtask

    // Waits (bounded) for busy and measures how many cycles it stays high
    task automatic expect_busy(input string tag, input int exp_len);
        int n = 0;
        int w = 0;
        @(negedge clk);
        while (!busy && w < 8) begin
            @(negedge clk);
            w++;
        end
        while (busy && n < B_LONG + 100) begin
            n++;
            @(negedge clk);
        end
        check_val({tag, "_busy_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic do_xfer(input string tag, input logic rs, input logic [7:0] d, input int width);
        int blen;
        model_apply(rs, d, blen);
        lcd_pulse(rs, 1'b0, d, width);
        expect_busy(tag, blen);
    endtask

    task automatic check_state(input string tag);
        @(posedge clk); #1;
        check_val({tag, "_ac"},   32'(cursor_addr),  32'(ac_m));
        check_val({tag, "_disp"}, 32'(display_on),   32'(disp_m));
        check_val({tag, "_err"},  32'(protocol_err), 32'(err_m));
        check_val({tag, "_cmds"}, 32'(cmd_seen),     32'(cmd_m));
        check_val({tag, "_data"}, 32'(dat_seen),     32'(dat_m));
        check_val({tag, "_busy"}, 32'(busy),         32'(0));
    endtask

    task automatic check_buffer(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1 rd_addr = 5'(i);
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("%s[%0d]", tag, i), 32'(rd_char), 32'(buf_m[i]));
        end
    endtask

    task automatic do_reset(input string tag);
        int n = 0;
        @(posedge clk); #1;
        reset = 1'b1; bus.lcd_en = 1'b0;
        repeat (3) @(posedge clk);
        check_val({tag, "_rdchar_rst"}, 32'(rd_char), 32'(0));
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_val({tag, "_init_busy"}, 32'(n), 32'(32));
    endtask

    task automatic rand_op(output logic rs, output logic [7:0] d);
        int k;
        int a;
        k = int'($urandom_range(0, 19));
        rs = 1'b0;
        if (k < 8 || k > 17) begin
            rs = 1'b1; d = 8'($urandom_range(33, 126));
        end else if (k < 11) begin
            a = int'($urandom_range(0, 79));
            d = 8'h80 | 8'((a < 40) ? a : a + 24);
        end else if (k == 11) d = 8'h04 | 8'($urandom_range(0, 3));
        else if (k == 12)     d = 8'h08 | 8'($urandom_range(0, 7));
        else if (k == 13)     d = 8'h10 | 8'($urandom_range(0, 15));
        else if (k == 14)     d = 8'h30 | 8'($urandom_range(0, 15));
        else if (k == 15)     d = 8'h40 | 8'($urandom_range(0, 63));
        else if (k == 16)     d = 8'h02 | 8'($urandom_range(0, 1));
        else                  d = 8'h01;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rs;
        logic [7:0] d;
        int         blen;
        int         w;
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
        rd_addr = 5'd0;
        reset = 1'b1;
        model_reset();

        do_reset("por");
        check_state("por");
        check_buffer("por_buf");

        // Row-1 page write
        do_xfer("c0", 1'b0, 8'hC0, 50);
        do_xfer("d31", 1'b1, 8'h31, 50);
        do_xfer("d32", 1'b1, 8'h32, 50);
        check_val("row1_ac", 32'(cursor_addr), 32'h42);
        check_state("row1");
        check_buffer("row1_buf");

        do_xfer("clear", 1'b0, 8'h01, 50);
        check_state("clear");
        check_buffer("clear_buf");

        // Off-screen write with wrap to row 1, then decrement wrap from 0
        do_xfer("a7", 1'b0, 8'hA7, 30);
        do_xfer("d41", 1'b1, 8'h41, 30);
        check_val("wrap_ac", 32'(cursor_addr), 32'h40);
        do_xfer("a0", 1'b0, 8'h80, 30);
        do_xfer("dec", 1'b0, 8'h04, 30);
        do_xfer("d42", 1'b1, 8'h42, 30);
        check_val("dec_ac", 32'(cursor_addr), 32'h67);
        check_state("dir");
        check_buffer("dir_buf");

        for (int t = 0; t < 30; t++) begin
            rand_op(rs, d);
            do_xfer($sformatf("rnd%0d", t), rs, d, int'($urandom_range(20, 60)));
            check_state($sformatf("rnd%0d", t));
            if (t % 6 == 5) check_buffer($sformatf("rnd%0d_buf", t));
        end

        // Rejected transfers: short en pulse and a read request
        err_m = 1'b1;
        lcd_pulse(1'b1, 1'b0, 8'h55, 5);
        expect_busy("short_en", 0);
        lcd_pulse(1'b1, 1'b1, 8'h56, 30);
        expect_busy("rw_read", 0);
        check_state("reject");
        check_buffer("reject_buf");

        // Reset in the middle of a clear
        model_apply(1'b0, 8'h01, blen);
        lcd_pulse(1'b0, 1'b0, 8'h01, 30);
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (60) @(posedge clk);
        do_reset("midrst");
        check_state("midrst");
        check_buffer("midrst_buf");

        // Second write issued about 100 cycles after the first
        model_apply(1'b1, 8'h61, blen);
        lcd_pulse(1'b1, 1'b0, 8'h61, 30);
        repeat (60) @(posedge clk);
        lcd_pulse(1'b1, 1'b0, 8'h62, 30);
`ifdef LCD_BUSY_CHECK_EN
        err_m = 1'b1;
`else
        model_apply(1'b1, 8'h62, blen);
`endif
        repeat (2 * B_SHORT + 100) @(posedge clk);
        check_state("overlap");
        check_buffer("overlap_buf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
